// File: rtl/cascade_pkg.sv
// Shared types and widths for the cascade feature/stage evaluation path.
package cascade_pkg;

  localparam int W_RECT   = 35;
  localparam int W_THR    = 13;
  localparam int W_VAR    = 18;
  localparam int W_LEAF   = 14;
  localparam int MAX_FEAT = 256;
  localparam int W_STAGE  = W_LEAF + $clog2(MAX_FEAT);

  // Feature sum holds up to 3 rectangle sums without overflow.
  localparam int W_FSUM = W_RECT + 2;
  // Signed threshold times unsigned (zero-extended) variance factor.
  localparam int W_PROD = W_THR + W_VAR + 1;
  // Common width for the threshold comparison.
  localparam int W_CMP  = (W_FSUM > W_PROD) ? W_FSUM : W_PROD;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    EVAL  = 2'd2,
    OUT   = 2'd3
  } state_t;

  // Sign-extend a leaf value to the stage accumulator width.
  function automatic logic signed [W_STAGE-1:0] sext(input logic signed [W_LEAF-1:0] v);
    return {{(W_STAGE-W_LEAF){v[W_LEAF-1]}}, v};
  endfunction

endpackage

// File: rtl/feat_thr_cmp.sv
// Combinational feature threshold test: lt = feat_sum < thr * var_norm.
// Kept separate so the multiplier can be pipelined without touching the FSM.
module feat_thr_cmp
  import cascade_pkg::*;
(
  input  logic signed [W_FSUM-1:0] feat_sum,
  input  logic signed [W_THR-1:0]  thr,
  input  logic        [W_VAR-1:0]  var_norm,
  output logic                     lt
);

  logic signed [W_PROD-1:0] thr_x;
  logic signed [W_PROD-1:0] var_x;
  logic signed [W_PROD-1:0] prod;
  logic signed [W_CMP-1:0]  sum_c;
  logic signed [W_CMP-1:0]  prod_c;

  // Scale threshold by the normalisation factor and compare signed.
  always_comb begin
    thr_x  = {{(W_PROD-W_THR){thr[W_THR-1]}}, thr};
    var_x  = {{(W_PROD-W_VAR){1'b0}}, var_norm};
    prod   = thr_x * var_x;
    sum_c  = W_CMP'(feat_sum);
    prod_c = W_CMP'(prod);
    lt     = (sum_c < prod_c);
  end

endmodule

// File: rtl/feature_stage_eval.sv
// Groups weighted rectangle sums into Haar features, applies the scaled
// threshold test per feature and accumulates leaf values into a stage sum.
// One pass/fail result is emitted per stage.
//
// Handshakes: every channel is valid/ready; a transfer happens on a posedge
// where both are high. Ready never depends on valid. Once dout_valid is high,
// dout_valid/dout_pass/dout_sum hold until the transfer.
module feature_stage_eval
  import cascade_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rect_valid,
  output logic                      rect_ready,
  input  logic signed [W_RECT-1:0]  rect_data,
  input  logic                      feat_valid,
  output logic                      feat_ready,
  input  logic        [1:0]         feat_rect_cnt,
  input  logic signed [W_THR-1:0]   feat_thr,
  input  logic signed [W_LEAF-1:0]  feat_left,
  input  logic signed [W_LEAF-1:0]  feat_right,
  input  logic                      feat_last,
  input  logic signed [W_STAGE-1:0] stage_thr,
  input  logic        [W_VAR-1:0]   var_norm,
  output logic                      dout_valid,
  input  logic                      dout_ready,
  output logic                      dout_pass,
  output logic signed [W_STAGE-1:0] dout_sum,
  output logic        [1:0]         state_dbg
);

  state_t state, state_next;

  logic                      first_flag;
  logic signed [W_THR-1:0]   thr_q;
  logic signed [W_LEAF-1:0]  left_q;
  logic signed [W_LEAF-1:0]  right_q;
  logic                      last_q;
  logic                      cnt3_q;
  logic        [1:0]         rcnt;
  logic signed [W_FSUM-1:0]  feat_sum;
  logic        [W_VAR-1:0]   var_q;
  logic signed [W_STAGE-1:0] stage_thr_q;
  logic signed [W_STAGE-1:0] stage_sum;
  logic                      lt;
  logic                      rect_last;

  // The rectangle completing the feature: index 1 for 2-rect, 2 for 3-rect.
  assign rect_last = (rcnt == (cnt3_q ? 2'd2 : 2'd1));
  assign state_dbg = state;

  feat_thr_cmp u_cmp (
    .feat_sum (feat_sum),
    .thr      (thr_q),
    .var_norm (var_q),
    .lt       (lt)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and handshake/output decode.
  always_comb begin
    state_next = state;
    feat_ready = 1'b0;
    rect_ready = 1'b0;
    dout_valid = 1'b0;
    dout_pass  = 1'b0;
    dout_sum   = '0;
    case (state)
      IDLE: begin
        feat_ready = 1'b1;
        if (feat_valid) state_next = ACCUM;
      end
      ACCUM: begin
        rect_ready = 1'b1;
        if (rect_valid && rect_last) state_next = EVAL;
      end
      EVAL: begin
        state_next = last_q ? OUT : IDLE;
      end
      OUT: begin
        dout_valid = 1'b1;
        dout_sum   = stage_sum;
        dout_pass  = (stage_sum >= stage_thr_q);
        if (dout_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Descriptor latching, feature accumulation and stage accumulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      first_flag  <= 1'b1;
      thr_q       <= '0;
      left_q      <= '0;
      right_q     <= '0;
      last_q      <= 1'b0;
      cnt3_q      <= 1'b0;
      rcnt        <= '0;
      feat_sum    <= '0;
      var_q       <= '0;
      stage_thr_q <= '0;
      stage_sum   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (feat_valid) begin
            thr_q    <= feat_thr;
            left_q   <= feat_left;
            right_q  <= feat_right;
            last_q   <= feat_last;
            // Counts 0 and 1 are treated as 2 rectangles.
            cnt3_q   <= (feat_rect_cnt == 2'd3);
            feat_sum <= '0;
            rcnt     <= '0;
            if (first_flag) begin
              stage_sum  <= '0;
              var_q      <= var_norm;
              first_flag <= 1'b0;
            end
            if (feat_last) stage_thr_q <= stage_thr;
          end
        end
        ACCUM: begin
          if (rect_valid) begin
            feat_sum <= feat_sum + W_FSUM'(rect_data);
            rcnt     <= rcnt + 2'd1;
          end
        end
        EVAL: begin
          // Accumulator wraps silently; unreachable for legal stage sizes.
          stage_sum <= stage_sum + sext(lt ? left_q : right_q);
        end
        OUT: begin
          if (dout_ready) first_flag <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_feature_stage_eval.sv
// Directed bench for feature_stage_eval with hand-computed stage results.
module tb_feature_stage_eval;
  import cascade_pkg::*;

  logic                      clk;
  logic                      rst;
  logic                      rect_valid;
  logic                      rect_ready;
  logic signed [W_RECT-1:0]  rect_data;
  logic                      feat_valid;
  logic                      feat_ready;
  logic        [1:0]         feat_rect_cnt;
  logic signed [W_THR-1:0]   feat_thr;
  logic signed [W_LEAF-1:0]  feat_left;
  logic signed [W_LEAF-1:0]  feat_right;
  logic                      feat_last;
  logic signed [W_STAGE-1:0] stage_thr;
  logic        [W_VAR-1:0]   var_norm;
  logic                      dout_valid;
  logic                      dout_ready;
  logic                      dout_pass;
  logic signed [W_STAGE-1:0] dout_sum;
  logic        [1:0]         state_dbg;

  int n_cmp = 0;
  int n_bad = 0;

  // Expected results as {pass, sum}.
  logic [W_STAGE:0] exp_q[$];

  feature_stage_eval dut (
    .clk           (clk),
    .rst           (rst),
    .rect_valid    (rect_valid),
    .rect_ready    (rect_ready),
    .rect_data     (rect_data),
    .feat_valid    (feat_valid),
    .feat_ready    (feat_ready),
    .feat_rect_cnt (feat_rect_cnt),
    .feat_thr      (feat_thr),
    .feat_left     (feat_left),
    .feat_right    (feat_right),
    .feat_last     (feat_last),
    .stage_thr     (stage_thr),
    .var_norm      (var_norm),
    .dout_valid    (dout_valid),
    .dout_ready    (dout_ready),
    .dout_pass     (dout_pass),
    .dout_sum      (dout_sum),
    .state_dbg     (state_dbg)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  // Driver tasks: called at a negedge, return at a negedge after the transfer.
  task automatic send_desc(input logic [1:0] cnt, input int thr, input int left, input int right,
                           input logic last, input int sthr, input int vn);
    int n;
    feat_rect_cnt = cnt;
    feat_thr      = W_THR'(thr);
    feat_left     = W_LEAF'(left);
    feat_right    = W_LEAF'(right);
    feat_last     = last;
    stage_thr     = W_STAGE'(sthr);
    var_norm      = W_VAR'(vn);
    feat_valid    = 1'b1;
    n = 0;
    while (!feat_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("desc_accept", {63'd0, feat_ready}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    feat_valid = 1'b0;
  endtask

  task automatic send_rect(input int d);
    int n;
    rect_data  = W_RECT'(d);
    rect_valid = 1'b1;
    n = 0;
    while (!rect_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rect_accept", {63'd0, rect_ready}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    rect_valid = 1'b0;
  endtask

  // Scoreboard side: wait for a result, compare with queue head, accept it.
  task automatic wait_out();
    int n;
    logic [W_STAGE:0] e;
    n = 0;
    while (!dout_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("dout_valid", {63'd0, dout_valid}, 64'd1);
    if (exp_q.size() == 0) e = '0;
    else e = exp_q.pop_front();
    check("dout_sum", 64'(dout_sum), 64'($signed(e[W_STAGE-1:0])));
    check("dout_pass", {63'd0, dout_pass}, {63'd0, e[W_STAGE]});
    dout_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dout_ready = 1'b0;
  endtask

  function automatic logic [W_STAGE:0] pack_exp(input logic pass, input int sum);
    return {pass, W_STAGE'(sum)};
  endfunction

  initial begin
    rst = 1'b1;
    rect_valid = 1'b0; rect_data = '0;
    feat_valid = 1'b0; feat_rect_cnt = '0; feat_thr = '0;
    feat_left = '0; feat_right = '0; feat_last = 1'b0;
    stage_thr = '0; var_norm = '0; dout_ready = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_rect_ready", {63'd0, rect_ready}, 64'd0);
    check("rst_feat_ready", {63'd0, feat_ready}, 64'd1);
    check("rst_dout_valid", {63'd0, dout_valid}, 64'd0);
    check("rst_dout_pass",  {63'd0, dout_pass},  64'd0);
    check("rst_dout_sum",   64'(dout_sum),       64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Rectangles offered while idle are not accepted.
    rect_valid = 1'b1; rect_data = W_RECT'(1000);
    @(negedge clk);
    check("idle_rect_ready", {63'd0, rect_ready}, 64'd0);
    @(negedge clk);
    check("idle_rect_ready2", {63'd0, rect_ready}, 64'd0);
    rect_valid = 1'b0;

    // T1: 2-rect, sum 90 < 100 -> left 5, 5 >= 4 pass.
    exp_q.push_back(pack_exp(1'b1, 5));
    send_desc(2'd2, 100, 5, -3, 1'b1, 4, 1);
    send_rect(60);
    send_rect(30);
    check("t1_eval_no_dout", {63'd0, dout_valid}, 64'd0);
    check("t1_eval_no_rect_ready", {63'd0, rect_ready}, 64'd0);
    @(negedge clk);
    check("t1_dout_latency", {63'd0, dout_valid}, 64'd1);
    wait_out();

    // T2: sum 110 -> right -3, fail; stage sum restarts from 0.
    exp_q.push_back(pack_exp(1'b0, -3));
    send_desc(2'd2, 100, 5, -3, 1'b1, 4, 1);
    send_rect(80);
    send_rect(30);
    wait_out();

    // T3: 3-rect, prod -40, sum -45 -> left 7, 7 < 8 fail.
    exp_q.push_back(pack_exp(1'b0, 7));
    send_desc(2'd3, -10, 7, -9, 1'b1, 8, 4);
    send_rect(-20);
    send_rect(-30);
    send_rect(5);
    wait_out();

    // T4: 3-feature stage, leaves 2,2,-1 -> 3 >= 3 pass, one result only.
    // Non-last descriptors carry stage_thr 100, which must not be latched.
    exp_q.push_back(pack_exp(1'b1, 3));
    send_desc(2'd0, 100, 2, -50, 1'b0, 100, 1);
    send_rect(1);
    send_rect(1);
    check("t4_f1_eval_no_dout", {63'd0, dout_valid}, 64'd0);
    @(negedge clk);
    check("t4_f1_idle_no_dout", {63'd0, dout_valid}, 64'd0);
    check("t4_f1_idle_feat_ready", {63'd0, feat_ready}, 64'd1);
    send_desc(2'd1, 100, 2, -50, 1'b0, 100, 1);
    send_rect(1);
    send_rect(1);
    @(negedge clk);
    check("t4_f2_no_dout", {63'd0, dout_valid}, 64'd0);
    send_desc(2'd2, 100, -1, -50, 1'b1, 3, 1);
    send_rect(1);
    send_rect(1);
    check("t4_f3_eval_no_dout", {63'd0, dout_valid}, 64'd0);
    wait_out();
    check("t4_single_pulse", {63'd0, dout_valid}, 64'd0);

    // T5: sum 0 not < 0 -> right -6, -6 >= -6 pass; hold in OUT.
    send_desc(2'd2, 0, 11, -6, 1'b1, -6, 3);
    send_rect(4);
    send_rect(-4);
    @(negedge clk);
    feat_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("t5_hold_valid", {63'd0, dout_valid}, 64'd1);
      check("t5_hold_sum", 64'(dout_sum), -64'sd6);
      check("t5_hold_pass", {63'd0, dout_pass}, 64'd1);
      check("t5_hold_feat_ready", {63'd0, feat_ready}, 64'd0);
      @(negedge clk);
    end
    feat_valid = 1'b0;
    exp_q.push_back(pack_exp(1'b1, -6));
    wait_out();
    check("t5_after_feat_ready", {63'd0, feat_ready}, 64'd1);

    // T6: reset mid-feature, then fresh stage with leaf 9 (9 < 10 fail).
    send_desc(2'd2, 100, 100, 100, 1'b1, 0, 1);
    send_rect(5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_rst_rect_ready", {63'd0, rect_ready}, 64'd0);
    check("t6_rst_feat_ready", {63'd0, feat_ready}, 64'd1);
    exp_q.push_back(pack_exp(1'b0, 9));
    send_desc(2'd2, 100, 9, -1, 1'b1, 10, 1);
    send_rect(10);
    send_rect(10);
    wait_out();

    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
